// File: rtl/shift_register_operand_iter.sv
// ============================================================================
// Module  : shift_register_operand_iter
// Brief   : Bit-serial ARM register-form operand-2 shifter (LSL/LSR/ASR/ROR/RRX)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_register_operand_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [11:0]      shifter_operand,
    input  logic [WIDTH-1:0] rm_value,
    input  logic [WIDTH-1:0] rs_value,
    input  logic             carryFlag,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_lsl = 2'b00;
    localparam logic [1:0] c_lsr = 2'b01;
    localparam logic [1:0] c_asr = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             wcarry_q, wcarry_d;
    logic [1:0]       type_q, type_d;
    logic             rrx_q, rrx_d;
    logic [5:0]       count_q, count_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;

    logic [5:0]       init_count;
    logic             init_carry;
    logic             init_rrx;
    logic [WIDTH-1:0] step_y;
    logic             step_c;

    // Decode of the request into a step count and starting carry
    always_comb begin
        logic [4:0] n_imm;
        logic [7:0] n_reg;
        n_imm      = shifter_operand[11:7];
        n_reg      = rs_value[7:0];
        init_count = 6'd0;
        init_carry = carryFlag;
        init_rrx   = 1'b0;
        if (!shifter_operand[4]) begin
            case (shifter_operand[6:5])
                c_lsl:   init_count = {1'b0, n_imm};
                c_lsr,
                c_asr:   init_count = (n_imm == 5'd0) ? 6'd32 : {1'b0, n_imm};
                default: begin
                    init_count = (n_imm == 5'd0) ? 6'd1 : {1'b0, n_imm};
                    init_rrx   = (n_imm == 5'd0);
                end
            endcase
        end else if (n_reg != 8'd0) begin
            case (shifter_operand[6:5])
                c_lsl,
                c_lsr:   init_count = (n_reg > 8'd33) ? 6'd33 : n_reg[5:0];
                c_asr:   init_count = (n_reg > 8'd32) ? 6'd32 : n_reg[5:0];
                default: begin
                    init_count = {1'b0, n_reg[4:0]};
                    // Rotation by a non-zero multiple of 32 leaves Rm intact but exposes bit 31
                    if (n_reg[4:0] == 5'd0) init_carry = rm_value[WIDTH-1];
                end
            endcase
        end
    end

    always_comb begin
        step_c = work_q[0];
        case (type_q)
            c_lsl: begin
                step_y = {work_q[WIDTH-2:0], 1'b0};
                step_c = work_q[WIDTH-1];
            end
            c_lsr:   step_y = {1'b0, work_q[WIDTH-1:1]};
            c_asr:   step_y = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: step_y = {(rrx_q ? wcarry_q : work_q[0]), work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        wcarry_d = wcarry_q;
        type_d   = type_q;
        rrx_d    = rrx_q;
        count_d  = count_q;
        y_d      = y_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d   = rm_value;
                    wcarry_d = init_carry;
                    type_d   = shifter_operand[6:5];
                    rrx_d    = init_rrx;
                    count_d  = init_count;
                    if (init_count == 6'd0) begin
                        y_d     = rm_value;
                        carry_d = init_carry;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d   = step_y;
                wcarry_d = step_c;
                count_d  = count_q - 6'd1;
                if (count_q == 6'd1) begin
                    y_d     = step_y;
                    carry_d = step_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            wcarry_q <= 1'b0;
            type_q   <= 2'b00;
            rrx_q    <= 1'b0;
            count_q  <= 6'd0;
            y_q      <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            wcarry_q <= wcarry_d;
            type_q   <= type_d;
            rrx_q    <= rrx_d;
            count_q  <= count_d;
            y_q      <= y_d;
            carry_q  <= carry_d;
        end
    end

    assign busy  = (state_q == SHIFT) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign Y     = y_q;
    assign carry = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_register_operand_iter.sv
// ============================================================================
// Module  : tb_shift_register_operand_iter
// Brief   : Directed self-checking bench for shift_register_operand_iter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_register_operand_iter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] shifter_operand;
    logic [31:0] rm_value;
    logic [31:0] rs_value;
    logic        carryFlag;
    logic        busy;
    logic        done;
    logic [31:0] Y;
    logic        carry;

    int n_checks = 0;
    int n_fail   = 0;

    shift_register_operand_iter #(.WIDTH(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .shifter_operand (shifter_operand),
        .rm_value        (rm_value),
        .rs_value        (rs_value),
        .carryFlag       (carryFlag),
        .busy            (busy),
        .done            (done),
        .Y               (Y),
        .carry           (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] enc(input logic [4:0] imm, input logic [1:0] typ, input logic byreg);
        return {imm, typ, byreg, 4'b0000};
    endfunction

    // Launches one request and waits for done; glitch_cyc > 0 pulses a stray start mid-operation
    task automatic run_op(input logic [11:0] op, input logic [31:0] rm, input logic [31:0] rs,
                          input logic cf, input int glitch_cyc,
                          output int lat, output logic busy_ok);
        int cyc;
        @(negedge clk);
        shifter_operand = op;
        rm_value        = rm;
        rs_value        = rs;
        carryFlag       = cf;
        start           = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        busy_ok = busy;
        while (!done && cyc < 60) begin
            if (cyc == glitch_cyc) begin
                start           = 1'b1;
                rm_value        = ~rm;
                shifter_operand = enc(5'd1, 2'b00, 1'b0);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            busy_ok = busy_ok & busy;
        end
        start = 1'b0;
        lat   = cyc;
    endtask

    task automatic do_op(input string tag, input logic [11:0] op, input logic [31:0] rm,
                         input logic [31:0] rs, input logic cf, input int glitch_cyc,
                         input int exp_lat, input logic [31:0] exp_y, input logic exp_c);
        int   lat;
        logic bok;
        run_op(op, rm, rs, cf, glitch_cyc, lat, bok);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " Y"}, Y, exp_y);
        check({tag, " carry"}, {31'd0, carry}, {31'd0, exp_c});
        check({tag, " busy"}, {31'd0, bok}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic bok;
        reset_n         = 1'b0;
        start           = 1'b0;
        shifter_operand = '0;
        rm_value        = '0;
        rs_value        = '0;
        carryFlag       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset Y", Y, 32'h0);
        check("reset carry", {31'd0, carry}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;

        do_op("lsl_imm4",   enc(5'd4, 2'b00, 1'b0), 32'h8000000F, 32'h0,  1'b0, 0, 5,  32'h000000F0, 1'b0);
        do_op("lsr_reg33",  enc(5'd0, 2'b01, 1'b1), 32'hFFFFFFFF, 32'h21, 1'b0, 0, 34, 32'h00000000, 1'b0);
        do_op("lsr_reg32",  enc(5'd0, 2'b01, 1'b1), 32'hFFFFFFFF, 32'h20, 1'b0, 0, 33, 32'h00000000, 1'b1);
        do_op("rrx",        enc(5'd0, 2'b11, 1'b0), 32'h00000003, 32'h0,  1'b1, 0, 2,  32'h80000001, 1'b1);
        do_op("ror_reg32",  enc(5'd0, 2'b11, 1'b1), 32'h80000001, 32'h20, 1'b0, 0, 1,  32'h80000001, 1'b1);
        do_op("ror_reg0",   enc(5'd0, 2'b11, 1'b1), 32'h80000001, 32'h00, 1'b0, 0, 1,  32'h80000001, 1'b0);
        do_op("lsl_imm0",   enc(5'd0, 2'b00, 1'b0), 32'h12345678, 32'h0,  1'b1, 0, 1,  32'h12345678, 1'b1);
        do_op("lsr_imm4",   enc(5'd4, 2'b01, 1'b0), 32'h0000001F, 32'h0,  1'b0, 0, 5,  32'h00000001, 1'b1);
        do_op("asr_imm4",   enc(5'd4, 2'b10, 1'b0), 32'h80000010, 32'h0,  1'b1, 0, 5,  32'hF8000001, 1'b0);
        do_op("ror_imm8",   enc(5'd8, 2'b11, 1'b0), 32'h000000AB, 32'h0,  1'b0, 0, 9,  32'hAB000000, 1'b1);
        do_op("asr_reg64",  enc(5'd0, 2'b10, 1'b1), 32'h40000000, 32'h40, 1'b1, 0, 33, 32'h00000000, 1'b0);
        do_op("asr_imm0",   enc(5'd0, 2'b10, 1'b0), 32'h80000000, 32'h0,  1'b0, 10, 33, 32'hFFFFFFFF, 1'b1);

        // The stray start must not have queued a second request
        @(negedge clk);
        @(negedge clk);
        check("no_queue done", {31'd0, done}, 32'd0);
        check("no_queue busy", {31'd0, busy}, 32'd0);
        check("no_queue Y", Y, 32'hFFFFFFFF);

        // Abort a long shift with reset at cycle 7
        @(negedge clk);
        shifter_operand = enc(5'd0, 2'b00, 1'b1);
        rm_value        = 32'h00000001;
        rs_value        = 32'd20;
        carryFlag       = 1'b0;
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort Y", Y, 32'h0);
        check("abort carry", {31'd0, carry}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort done", {31'd0, done}, 32'd0);

        run_op(enc(5'd0, 2'b00, 1'b1), 32'h00000001, 32'd20, 1'b0, 0, lat, bok);
        check("fresh latency", lat, 21);
        check("fresh Y", Y, 32'h00100000);
        check("fresh carry", {31'd0, carry}, 32'd0);
        check("fresh busy", {31'd0, bok}, 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
